// File: rtl/vga_capture_pkg.sv
// Shared types and geometry for the frame capture block.
// Holds the capture/readout state enums, the stored-frame geometry of the
// default 640x480 / 4x-decimation configuration, and a depth helper.
// Instances derive their own geometry from their parameters.
package vga_capture_pkg;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT,
    C_CAPTURE
  } capture_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_VALID
  } read_state_t;

  localparam int SW        = 640 >> 2;
  localparam int SH        = 480 >> 2;
  localparam int SW_BITS   = $clog2(SW);
  localparam int SH_BITS   = $clog2(SH);
  localparam int MEM_DEPTH = 2 ** (1 + SW_BITS + SH_BITS);

  // Two banks of a stored frame, bank bit on top of {row, column}.
  function automatic int mem_depth(input int sw_bits, input int sh_bits);
    return 2 ** (1 + sw_bits + sh_bits);
  endfunction

endpackage

// File: rtl/frame_capture_ram.sv
// Simple dual-port frame RAM for frame_capture.
// Ports:
//   clock_in, reset_n_in         pixel clock, async active-low reset
//   write_enable/addr/data       one write per cycle
//   read_enable/addr             read request, data appears next cycle
//   read_data                    registered read data (cleared by reset)
// The address MSB selects the bank. Array contents are not reset.
module frame_capture_ram
  import vga_capture_pkg::*;
#(
  parameter int ADDR_BITS = 1 + SW_BITS + SH_BITS,
  parameter int DATA_BITS = 12,
  parameter int DEPTH     = MEM_DEPTH
) (
  input  logic                 clock_in,
  input  logic                 reset_n_in,
  input  logic                 write_enable,
  input  logic [ADDR_BITS-1:0] write_addr,
  input  logic [DATA_BITS-1:0] write_data,
  input  logic                 read_enable,
  input  logic [ADDR_BITS-1:0] read_addr,
  output logic [DATA_BITS-1:0] read_data
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clock_in) begin
    if (write_enable) mem[write_addr] <= write_data;
  end

  // Only the output register is reset so the read port reads 0 after reset.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in)      read_data <= '0;
    else if (read_enable) read_data <= mem[read_addr];
  end

endmodule

// File: rtl/frame_capture.sv
// Decimating double-buffered frame capture beside the VGA timing generator.
// Captures every 2^SCALE_SHIFT-th pixel in x and y into the write bank,
// swaps banks at each frame boundary (unless a readout holds the read bank),
// and streams the last committed frame over a valid/ready port.
// Ports:
//   clock_in, reset_n_in                 pixel clock, async active-low reset
//   pixel_x/y_in, pixel_in, video_on_in  video stream
//   v_sync_in                            active-low vertical sync
//   capture_enable_in                    arm capture
//   read_request_in, read_ready_in       readout start pulse, consumer ready
//   read_valid/data/x/y/last_out         readout stream
//   read_busy_out                        readout in progress
//   frame_ready_out                      a committed frame exists (sticky)
//   frame_dropped_out                    pulse: finished frame discarded
//   frame_count_out                      committed frame count (wraps)
//
// Capture FSM
//   state     | meaning
//   C_IDLE    | not capturing
//   C_WAIT    | armed, waiting for the next frame boundary
//   C_CAPTURE | writing pixels; commit or drop at each frame boundary
// Read FSM
//   state     | meaning
//   R_IDLE    | no readout
//   R_FETCH   | RAM read in flight for the current (x, y)
//   R_VALID   | data presented, waiting for read_ready_in
module frame_capture
  import vga_capture_pkg::*;
#(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int WIDTH_BITS  = 10,
  parameter int HEIGHT_BITS = 9,
  parameter int PIXEL_BITS  = 12,
  parameter int SCALE_SHIFT = 2,
  parameter int COUNT_BITS  = 16
) (
  input  logic                            clock_in,
  input  logic                            reset_n_in,
  input  logic [WIDTH_BITS-1:0]           pixel_x_in,
  input  logic [HEIGHT_BITS-1:0]          pixel_y_in,
  input  logic [PIXEL_BITS-1:0]           pixel_in,
  input  logic                            video_on_in,
  input  logic                            v_sync_in,
  input  logic                            capture_enable_in,
  input  logic                            read_request_in,
  input  logic                            read_ready_in,
  output logic                            read_valid_out,
  output logic [PIXEL_BITS-1:0]           read_data_out,
  output logic [WIDTH_BITS-SCALE_SHIFT-1:0]  read_x_out,
  output logic [HEIGHT_BITS-SCALE_SHIFT-1:0] read_y_out,
  output logic                            read_last_out,
  output logic                            read_busy_out,
  output logic                            frame_ready_out,
  output logic                            frame_dropped_out,
  output logic [COUNT_BITS-1:0]           frame_count_out
);

  localparam int XS_BITS   = WIDTH_BITS - SCALE_SHIFT;
  localparam int YS_BITS   = HEIGHT_BITS - SCALE_SHIFT;
  localparam int ADDR_BITS = 1 + XS_BITS + YS_BITS;
  localparam int DEPTH     = mem_depth(XS_BITS, YS_BITS);

  localparam logic [XS_BITS-1:0]     X_LAST  = XS_BITS'((WIDTH >> SCALE_SHIFT) - 1);
  localparam logic [YS_BITS-1:0]     Y_LAST  = YS_BITS'((HEIGHT >> SCALE_SHIFT) - 1);
  localparam logic [WIDTH_BITS:0]    X_LIMIT = (WIDTH_BITS + 1)'(WIDTH);
  localparam logic [HEIGHT_BITS:0]   Y_LIMIT = (HEIGHT_BITS + 1)'(HEIGHT);
  localparam logic [WIDTH_BITS-1:0]  X_SUB   = WIDTH_BITS'((1 << SCALE_SHIFT) - 1);
  localparam logic [HEIGHT_BITS-1:0] Y_SUB   = HEIGHT_BITS'((1 << SCALE_SHIFT) - 1);

  capture_state_t cap_state, cap_next;
  read_state_t    rd_state, rd_next;

  logic                  vsync_q;
  logic                  frame_edge;
  logic                  commit, drop;
  logic                  wr_bank_q;
  logic                  rd_bank_q;
  logic                  frame_ready_q;
  logic                  dropped_q;
  logic [COUNT_BITS-1:0] frame_count_q;
  logic                  accept, advance;
  logic [XS_BITS-1:0]    rd_x_q;
  logic [YS_BITS-1:0]    rd_y_q;
  logic                  at_last;
  logic                  read_busy;
  logic                  wr_en;
  logic [ADDR_BITS-1:0]  wr_addr, rd_addr;

  assign frame_edge = vsync_q & ~v_sync_in;
  assign read_busy  = (rd_state != R_IDLE);
  assign at_last    = (rd_x_q == X_LAST) && (rd_y_q == Y_LAST);

  // ---------------- capture FSM ----------------
  always_comb begin
    cap_next = cap_state;
    commit   = 1'b0;
    drop     = 1'b0;
    case (cap_state)
      C_IDLE:  if (capture_enable_in) cap_next = C_WAIT;
      C_WAIT:  if (frame_edge) cap_next = C_CAPTURE;
      C_CAPTURE: begin
        if (frame_edge) begin
          // A busy readout owns the read bank, so the finished frame is lost
          // and the write bank is simply reused for the next frame.
          if (read_busy) drop = 1'b1;
          else           commit = 1'b1;
          cap_next = capture_enable_in ? C_CAPTURE : C_IDLE;
        end
      end
      default: cap_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      cap_state     <= C_IDLE;
      vsync_q       <= 1'b0;
      wr_bank_q     <= 1'b0;
      frame_ready_q <= 1'b0;
      dropped_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      cap_state <= cap_next;
      vsync_q   <= v_sync_in;
      dropped_q <= drop;
      if (commit) begin
        wr_bank_q     <= ~wr_bank_q;
        frame_ready_q <= 1'b1;
        frame_count_q <= frame_count_q + 1'b1;
      end
    end
  end

  assign wr_en = (cap_state == C_CAPTURE) && video_on_in
              && ({1'b0, pixel_x_in} < X_LIMIT) && ({1'b0, pixel_y_in} < Y_LIMIT)
              && ((pixel_x_in & X_SUB) == '0) && ((pixel_y_in & Y_SUB) == '0);

  assign wr_addr = {wr_bank_q, pixel_y_in[HEIGHT_BITS-1:SCALE_SHIFT],
                    pixel_x_in[WIDTH_BITS-1:SCALE_SHIFT]};

  // ---------------- read FSM ----------------
  always_comb begin
    rd_next = rd_state;
    accept  = 1'b0;
    advance = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (read_request_in && frame_ready_q) begin
          accept  = 1'b1;
          rd_next = R_FETCH;
        end
      end
      R_FETCH: rd_next = R_VALID;
      R_VALID: begin
        if (read_ready_in) begin
          if (at_last) begin
            rd_next = R_IDLE;
          end else begin
            advance = 1'b1;
            rd_next = R_FETCH;
          end
        end
      end
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      rd_state  <= R_IDLE;
      rd_bank_q <= 1'b1;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
    end else begin
      rd_state <= rd_next;
      if (accept) begin
        rd_x_q <= '0;
        rd_y_q <= '0;
        // A swap in the same cycle wins: the bank being committed right now
        // is the one to read.
        rd_bank_q <= commit ? wr_bank_q : ~wr_bank_q;
      end else if (advance) begin
        if (rd_x_q == X_LAST) begin
          rd_x_q <= '0;
          rd_y_q <= rd_y_q + 1'b1;
        end else begin
          rd_x_q <= rd_x_q + 1'b1;
        end
      end
    end
  end

  assign rd_addr = {rd_bank_q, rd_y_q, rd_x_q};

  frame_capture_ram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (PIXEL_BITS),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clock_in     (clock_in),
    .reset_n_in   (reset_n_in),
    .write_enable (wr_en),
    .write_addr   (wr_addr),
    .write_data   (pixel_in),
    .read_enable  (rd_state == R_FETCH),
    .read_addr    (rd_addr),
    .read_data    (read_data_out)
  );

  assign read_valid_out    = (rd_state == R_VALID);
  assign read_last_out     = (rd_state == R_VALID) && at_last;
  assign read_x_out        = rd_x_q;
  assign read_y_out        = rd_y_q;
  assign read_busy_out     = read_busy;
  assign frame_ready_out   = frame_ready_q;
  assign frame_dropped_out = dropped_q;
  assign frame_count_out   = frame_count_q;

endmodule

// File: tb/tb_frame_capture.sv
// Self-checking bench for frame_capture on an 8x4 raster decimated to 4x2.
// A frame-level model tracks the frame being captured and the last
// committed frame; readouts are compared pixel by pixel against it.
module tb_frame_capture;

  localparam int WIDTH       = 8;
  localparam int HEIGHT      = 4;
  localparam int WIDTH_BITS  = 3;
  localparam int HEIGHT_BITS = 2;
  localparam int PIXEL_BITS  = 12;
  localparam int SCALE_SHIFT = 1;
  localparam int COUNT_BITS  = 16;
  localparam int SW          = 4;
  localparam int SH          = 2;
  localparam int NPIX        = SW * SH;

  logic                   clock_in = 1'b0;
  logic                   reset_n_in;
  logic [WIDTH_BITS-1:0]  pixel_x_in;
  logic [HEIGHT_BITS-1:0] pixel_y_in;
  logic [PIXEL_BITS-1:0]  pixel_in;
  logic                   video_on_in;
  logic                   v_sync_in;
  logic                   capture_enable_in;
  logic                   read_request_in;
  logic                   read_ready_in;
  logic                   read_valid_out;
  logic [PIXEL_BITS-1:0]  read_data_out;
  logic [1:0]             read_x_out;
  logic [0:0]             read_y_out;
  logic                   read_last_out;
  logic                   read_busy_out;
  logic                   frame_ready_out;
  logic                   frame_dropped_out;
  logic [COUNT_BITS-1:0]  frame_count_out;

  frame_capture #(
    .WIDTH       (WIDTH),
    .HEIGHT      (HEIGHT),
    .WIDTH_BITS  (WIDTH_BITS),
    .HEIGHT_BITS (HEIGHT_BITS),
    .PIXEL_BITS  (PIXEL_BITS),
    .SCALE_SHIFT (SCALE_SHIFT),
    .COUNT_BITS  (COUNT_BITS)
  ) dut (
    .clock_in          (clock_in),
    .reset_n_in        (reset_n_in),
    .pixel_x_in        (pixel_x_in),
    .pixel_y_in        (pixel_y_in),
    .pixel_in          (pixel_in),
    .video_on_in       (video_on_in),
    .v_sync_in         (v_sync_in),
    .capture_enable_in (capture_enable_in),
    .read_request_in   (read_request_in),
    .read_ready_in     (read_ready_in),
    .read_valid_out    (read_valid_out),
    .read_data_out     (read_data_out),
    .read_x_out        (read_x_out),
    .read_y_out        (read_y_out),
    .read_last_out     (read_last_out),
    .read_busy_out     (read_busy_out),
    .frame_ready_out   (frame_ready_out),
    .frame_dropped_out (frame_dropped_out),
    .frame_count_out   (frame_count_out)
  );

  always #5 clock_in = ~clock_in;

  int checks = 0;
  int errors = 0;
  int drop_seen = 0;

  // Counts cycles with the drop flag high, so a stretched pulse shows up too.
  always @(negedge clock_in) if (reset_n_in && frame_dropped_out) drop_seen++;

  // Frame-level model: 0 = not capturing, 1 = armed, 2 = capturing.
  int              m_cap;
  bit              m_en, m_ready, m_busy;
  int              m_count, m_drops;
  int              r_idx;
  logic [11:0]     pend [NPIX];
  logic [11:0]     committed [NPIX];
  logic [11:0]     rexp [NPIX];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock_in);
  endtask

  task automatic model_reset();
    m_cap = 0; m_ready = 0; m_busy = 0; m_count = 0;
    m_en = capture_enable_in;
  endtask

  task automatic model_edge();
    if (m_cap == 2) begin
      if (m_busy) m_drops++;
      else begin
        committed = pend;
        m_count = (m_count + 1) % 65536;
        m_ready = 1;
      end
      if (!m_en) m_cap = 0;
    end else if (m_cap == 1) begin
      m_cap = 2;
    end
  endtask

  task automatic set_enable(input bit v);
    capture_enable_in = v;
    m_en = v;
    if (v && m_cap == 0) m_cap = 1;
    tick();
  endtask

  task automatic vsync_pulse();
    video_on_in = 0;
    v_sync_in = 0;
    tick(); tick();
    model_edge();
    v_sync_in = 1;
    tick(); tick();
  endtask

  // pattern=1 drives pixel = {y, x}; otherwise random colours.
  task automatic active_frame(input bit pattern, input int dis_y);
    for (int y = 0; y < HEIGHT; y++) begin
      for (int x = 0; x < WIDTH; x++) begin
        if (y == dis_y && x == 3) begin
          capture_enable_in = 0;
          m_en = 0;
        end
        pixel_x_in  = 3'(x);
        pixel_y_in  = 2'(y);
        video_on_in = 1;
        pixel_in    = pattern ? 12'({2'(y), 3'(x)}) : 12'($urandom);
        if (m_cap == 2 && x % 2 == 0 && y % 2 == 0) pend[(y / 2) * SW + x / 2] = pixel_in;
        tick();
      end
      // Blanking cycle sitting on a stored coordinate must not write.
      video_on_in = 0;
      pixel_x_in  = 0;
      pixel_in    = 12'($urandom);
      tick();
    end
  endtask

  task automatic start_read();
    read_request_in = 1;
    tick();
    read_request_in = 0;
    check("req_busy", read_busy_out, m_ready);
    check("req_valid", read_valid_out, 0);
    if (m_ready) begin
      rexp   = committed;
      r_idx  = 0;
      m_busy = 1;
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: ready pattern 1-0-0-1.
  task automatic consume(input int n, input int mode);
    int budget = 400;
    int got = 0;
    int phase = 0;
    bit hold = 0;
    bit rdy;
    logic [11:0] hd;
    logic [1:0]  hx;
    logic        hy;
    while (got < n && budget > 0) begin
      budget--;
      if (hold) begin
        check("hold_valid", read_valid_out, 1);
        check("hold_data", read_data_out, hd);
        check("hold_x", read_x_out, hx);
        check("hold_y", read_y_out, hy);
      end
      hold = 0;
      if (read_valid_out) begin
        check("rd_data", read_data_out, rexp[r_idx]);
        check("rd_x", read_x_out, r_idx % SW);
        check("rd_y", read_y_out, r_idx / SW);
        check("rd_last", read_last_out, r_idx == NPIX - 1);
        case (mode)
          0:       rdy = 1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: rdy = (phase % 4 == 0) || (phase % 4 == 3);
        endcase
        phase++;
        read_ready_in = rdy;
        if (rdy) begin
          got++;
          r_idx++;
        end else begin
          hold = 1;
          hd = read_data_out;
          hx = read_x_out;
          hy = read_y_out;
        end
      end else begin
        read_ready_in = 0;
      end
      tick();
    end
    read_ready_in = 0;
    if (got < n) check("rd_timeout", got, n);
    if (r_idx == NPIX) begin
      m_busy = 0;
      check("rd_end_busy", read_busy_out, 0);
      check("rd_end_valid", read_valid_out, 0);
    end
  endtask

  task automatic check_zero();
    check("z_valid", read_valid_out, 0);
    check("z_data", read_data_out, 0);
    check("z_x", read_x_out, 0);
    check("z_y", read_y_out, 0);
    check("z_last", read_last_out, 0);
    check("z_busy", read_busy_out, 0);
    check("z_ready", frame_ready_out, 0);
    check("z_drop", frame_dropped_out, 0);
    check("z_count", frame_count_out, 0);
  endtask

  initial begin
    reset_n_in = 0;
    pixel_x_in = 0; pixel_y_in = 0; pixel_in = 0;
    video_on_in = 0; v_sync_in = 1;
    capture_enable_in = 0; read_request_in = 0; read_ready_in = 0;
    m_drops = 0;
    model_reset();
    tick(); tick(); tick();
    check_zero();
    reset_n_in = 1;
    tick();

    // Request before any frame is ready is ignored.
    start_read();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("early_valid", read_valid_out, 0);
      check("early_busy", read_busy_out, 0);
    end

    // First frame: arm, boundary, {y,x} pattern, boundary commits.
    set_enable(1);
    vsync_pulse();
    check("f0_ready", frame_ready_out, m_ready);
    check("f0_count", frame_count_out, m_count);
    active_frame(1, -1);
    vsync_pulse();
    check("f1_ready", frame_ready_out, m_ready);
    check("f1_count", frame_count_out, m_count);
    start_read();
    consume(NPIX, 0);

    // Backpressure with ready pattern 1-0-0-1.
    active_frame(0, -1);
    vsync_pulse();
    check("f2_count", frame_count_out, m_count);
    start_read();
    consume(NPIX, 2);

    // Frame boundary during readout drops the finished frame.
    active_frame(0, -1);
    start_read();
    consume(3, 0);
    vsync_pulse();
    check("drop_seen", drop_seen, m_drops);
    check("drop_count", frame_count_out, m_count);
    check("drop_pulse_end", frame_dropped_out, 0);
    consume(NPIX - 3, 1);
    active_frame(0, -1);
    vsync_pulse();
    check("f3_count", frame_count_out, m_count);
    check("f3_drops", drop_seen, m_drops);
    start_read();
    consume(NPIX, 1);

    // Disable mid-frame: the frame still commits, later frames do not.
    active_frame(0, 1);
    vsync_pulse();
    check("dis_count", frame_count_out, m_count);
    active_frame(0, -1);
    vsync_pulse();
    active_frame(0, -1);
    vsync_pulse();
    check("idle_count", frame_count_out, m_count);
    check("idle_drops", drop_seen, m_drops);
    start_read();
    consume(NPIX, 1);

    // Asynchronous reset while data is presented.
    start_read();
    consume(2, 0);
    tick(); tick();
    check("pre_rst_valid", read_valid_out, 1);
    #2;
    reset_n_in = 0;
    #1;
    check_zero();
    tick(); tick();
    reset_n_in = 1;
    model_reset();
    tick();
    start_read();
    tick();
    check("post_rst_valid", read_valid_out, 0);
    set_enable(1);
    vsync_pulse();
    active_frame(0, -1);
    vsync_pulse();
    check("post_rst_count", frame_count_out, m_count);
    check("post_rst_ready", frame_ready_out, m_ready);
    start_read();
    consume(NPIX, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
